// File: rtl/spi_byte_sequencer.sv
// spi_byte_sequencer
// Feeds a byte-level SPI master from a small TX FIFO. Each buffered byte is
// launched with a one-cycle start pulse. The byte received for it is
// presented on a valid/ready RX port. A watchdog aborts a transfer when the
// master never raises busy, or never drops it, within TIMEOUT_CYCLES cycles.
module spi_byte_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          spi_start,
    output logic [7:0]                    spi_data_in,
    input  logic                          spi_busy,
    input  logic [7:0]                    spi_data_out,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic                          timeout_err,
    input  logic                          err_clr
);

    localparam int              AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     DEPTH_L = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]     LVL_ONE = (AW+1)'(1);
    localparam logic [AW-1:0]   PTR_ONE = AW'(1);
    localparam logic [15:0]     TMO_L   = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [7:0]      spi_data_in_q, spi_data_in_d;
    logic            spi_start_q, spi_start_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            err_q, err_d;
    logic [15:0]     wd_q, wd_d;

    logic            tx_ready_s;
    logic            push_s;
    logic            pop_s;
    logic            timeout_s;
    logic [15:0]     wd_inc_s;

    // A full FIFO refuses a push even when the same edge pops, because
    // readiness comes from the registered count only.
    assign tx_ready_s = rst_n && (count_q < DEPTH_L);
    assign push_s     = tx_valid && tx_ready_s;
    assign wd_inc_s   = wd_q + 16'd1;

    // Sequencer FSM: launch decision, busy tracking, RX capture and watchdog.
    always_comb begin
        state_d       = state_q;
        rd_ptr_d      = rd_ptr_q;
        spi_data_in_d = spi_data_in_q;
        rx_data_d     = rx_data_q;
        wd_d          = wd_q;
        pop_s         = 1'b0;
        timeout_s     = 1'b0;
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
        case (state_q)
            ST_IDLE: begin
                // A pending RX byte blocks the next launch, so a slow
                // consumer stalls TX instead of losing data.
                if ((count_q != '0) && !rx_valid_q) begin
                    pop_s         = 1'b1;
                    spi_data_in_d = mem_q[rd_ptr_q];
                    rd_ptr_d      = rd_ptr_q + PTR_ONE;
                    state_d       = ST_LAUNCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                wd_d    = 16'd0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (spi_busy) begin
                    wd_d    = 16'd0;
                    state_d = ST_WAIT_DONE;
                end else if (wd_inc_s == TMO_L) begin
                    timeout_s = 1'b1;
                    wd_d      = 16'd0;
                    state_d   = ST_IDLE;
                end else begin
                    wd_d = wd_inc_s;
                end
            end
            ST_WAIT_DONE: begin
                if (!spi_busy) begin
                    rx_data_d  = spi_data_out;
                    rx_valid_d = 1'b1;
                    wd_d       = 16'd0;
                    state_d    = ST_IDLE;
                end else if (wd_inc_s == TMO_L) begin
                    // The aborted byte is dropped, not re-queued.
                    timeout_s = 1'b1;
                    wd_d      = 16'd0;
                    state_d   = ST_IDLE;
                end else begin
                    wd_d = wd_inc_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping, sticky error flag and registered start pulse.
    always_comb begin
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + LVL_ONE;
            2'b01:   count_d = count_q - LVL_ONE;
            default: count_d = count_q;
        endcase
        // A new timeout wins over a clear arriving on the same edge.
        if (timeout_s) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
        spi_start_d = (state_d == ST_LAUNCH);
    end

    // State and control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            spi_data_in_q <= 8'h00;
            spi_start_q   <= 1'b0;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            err_q         <= 1'b0;
            wd_q          <= 16'd0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            spi_data_in_q <= spi_data_in_d;
            spi_start_q   <= spi_start_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            err_q         <= err_d;
            wd_q          <= wd_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    assign tx_ready    = tx_ready_s;
    assign tx_level    = count_q;
    assign spi_start   = spi_start_q;
    assign spi_data_in = spi_data_in_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Directed testbench for spi_byte_sequencer with a simple SPI slave model
// that answers each byte with (mosi ^ 0x99) after a fixed busy period.
module tb_spi_byte_sequencer;

    localparam int DEPTH    = 4;
    localparam int TMO      = 16;
    localparam int SLV_BUSY = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       spi_start;
    logic [7:0] spi_data_in;
    logic       spi_busy;
    logic [7:0] spi_data_out;
    logic [2:0] tx_level;
    logic       timeout_err;
    logic       err_clr;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         start_cnt = 0;
    logic [7:0] rx_q[$];
    logic [7:0] mosi_q[$];
    bit         slave_en = 1'b1;
    bit         chk_hold = 1'b1;

    always #5 clk = ~clk;

    spi_byte_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .spi_start(spi_start), .spi_data_in(spi_data_in),
        .spi_busy(spi_busy), .spi_data_out(spi_data_out),
        .tx_level(tx_level), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    // Monitor: counts start pulses and logs RX handshakes (after inputs settle).
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n === 1'b1 && spi_start === 1'b1) start_cnt++;
            if (rst_n === 1'b1 && rx_valid === 1'b1 && rx_ready === 1'b1) rx_q.push_back(rx_data);
        end
    end

    // Slave model: on a start pulse, go busy, hold, then return mosi ^ 0x99.
    initial begin
        forever begin
            @(negedge clk);
            if (slave_en && rst_n === 1'b1 && spi_start === 1'b1) begin
                logic [7:0] b;
                b = spi_data_in;
                mosi_q.push_back(b);
                @(negedge clk);
                spi_busy = 1'b1;
                for (int i = 0; i < SLV_BUSY; i++) begin
                    @(negedge clk);
                    if (chk_hold) begin
                        n_cmp++;
                        if (spi_data_in !== b) begin n_fail++; $display("FAIL mosi_hold: got %h required %h", spi_data_in, b); end
                    end
                end
                spi_data_out = b ^ 8'h99;
                spi_busy = 1'b0;
            end
        end
    end

    task automatic push_byte(input logic [7:0] b, output bit ok);
        bit acc;
        ok = 1'b0;
        tx_data = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            acc = tx_ready;
            @(negedge clk);
            if (acc) ok = 1'b1;
        end
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b1;
        spi_busy = 1'b0; spi_data_out = 8'h00; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_tx_ready: got %b required 0", tx_ready); end
        n_cmp++; if (tx_level !== 3'd0) begin n_fail++; $display("FAIL rst_level: got %0d required 0", tx_level); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rx_valid: got %b required 0", rx_valid); end
        n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_rx_data: got %h required 00", rx_data); end
        n_cmp++; if (spi_start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b required 0", spi_start); end
        n_cmp++; if (spi_data_in !== 8'h00) begin n_fail++; $display("FAIL rst_mosi: got %h required 00", spi_data_in); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b required 0", timeout_err); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b required 1", tx_ready); end
    endtask

    task automatic test_single_byte();
        bit ok;
        int base_rx;
        int base_st;
        base_rx = rx_q.size(); base_st = start_cnt;
        push_byte(8'hA5, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_push: got %b required 1", ok); end
        n_cmp++; if (spi_start !== 1'b0) begin n_fail++; $display("FAIL single_start_early: got %b required 0", spi_start); end
        n_cmp++; if (tx_level !== 3'd1) begin n_fail++; $display("FAIL single_level1: got %0d required 1", tx_level); end
        @(negedge clk);
        n_cmp++; if (spi_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b required 1", spi_start); end
        n_cmp++; if (spi_data_in !== 8'hA5) begin n_fail++; $display("FAIL single_mosi: got %h required a5", spi_data_in); end
        n_cmp++; if (tx_level !== 3'd0) begin n_fail++; $display("FAIL single_level0: got %0d required 0", tx_level); end
        for (int i = 0; i < 100 && rx_valid !== 1'b1; i++) @(negedge clk);
        n_cmp++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL single_rx_valid: got %b required 1", rx_valid); end
        n_cmp++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL single_rx_data: got %h required 3c", rx_data); end
        @(negedge clk);
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL single_rx_drop: got %b required 0", rx_valid); end
        n_cmp++; if (start_cnt - base_st !== 1) begin n_fail++; $display("FAIL single_starts: got %0d required 1", start_cnt - base_st); end
        n_cmp++; if (rx_q.size() - base_rx !== 1) begin n_fail++; $display("FAIL single_rx_count: got %0d required 1", rx_q.size() - base_rx); end
    endtask

    task automatic test_push_pop_same_cycle();
        bit ok;
        int base_rx;
        int base_mo;
        base_rx = rx_q.size(); base_mo = mosi_q.size();
        push_byte(8'h66, ok);
        push_byte(8'h77, ok);
        n_cmp++; if (tx_level !== 3'd1) begin n_fail++; $display("FAIL pp_level: got %0d required 1", tx_level); end
        n_cmp++; if (spi_start !== 1'b1) begin n_fail++; $display("FAIL pp_start: got %b required 1", spi_start); end
        n_cmp++; if (spi_data_in !== 8'h66) begin n_fail++; $display("FAIL pp_mosi: got %h required 66", spi_data_in); end
        for (int i = 0; i < 200 && rx_q.size() < base_rx + 2; i++) @(negedge clk);
        n_cmp++;
        if (rx_q.size() != base_rx + 2) begin n_fail++; $display("FAIL pp_rx_count: got %0d required 2", rx_q.size() - base_rx); end
        else begin
            n_cmp++; if (rx_q[base_rx] !== 8'hFF) begin n_fail++; $display("FAIL pp_rx0: got %h required ff", rx_q[base_rx]); end
            n_cmp++; if (rx_q[base_rx+1] !== 8'hEE) begin n_fail++; $display("FAIL pp_rx1: got %h required ee", rx_q[base_rx+1]); end
            n_cmp++; if (mosi_q[base_mo+1] !== 8'h77) begin n_fail++; $display("FAIL pp_mosi1: got %h required 77", mosi_q[base_mo+1]); end
        end
    endtask

    task automatic test_burst_full();
        bit ok;
        int base_rx;
        int base_mo;
        logic [7:0] exp_rx [6];
        logic [7:0] exp_mo [6];
        exp_mo = '{8'hF0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        exp_rx = '{8'h69, 8'h98, 8'h9B, 8'h9A, 8'h9D, 8'h9C};
        base_rx = rx_q.size(); base_mo = mosi_q.size();
        rx_ready = 1'b0;
        push_byte(8'hF0, ok);
        for (int i = 0; i < 100 && rx_valid !== 1'b1; i++) @(negedge clk);
        n_cmp++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL burst_pre_rx: got %b required 1", rx_valid); end
        for (int k = 1; k <= 4; k++) push_byte(8'(k), ok);
        n_cmp++; if (tx_level !== 3'd4) begin n_fail++; $display("FAIL burst_full_level: got %0d required 4", tx_level); end
        n_cmp++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL burst_full_ready: got %b required 0", tx_ready); end
        tx_data = 8'h05; tx_valid = 1'b1; rx_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (tx_level !== 3'd4) begin n_fail++; $display("FAIL burst_hold_level: got %0d required 4", tx_level); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL burst_hs: got %b required 0", rx_valid); end
        @(negedge clk);
        n_cmp++; if (tx_level !== 3'd3) begin n_fail++; $display("FAIL burst_pop_no_push: got %0d required 3", tx_level); end
        n_cmp++; if (spi_start !== 1'b1) begin n_fail++; $display("FAIL burst_start: got %b required 1", spi_start); end
        n_cmp++; if (spi_data_in !== 8'h01) begin n_fail++; $display("FAIL burst_mosi0: got %h required 01", spi_data_in); end
        @(negedge clk);
        tx_valid = 1'b0;
        n_cmp++; if (tx_level !== 3'd4) begin n_fail++; $display("FAIL burst_fifth_in: got %0d required 4", tx_level); end
        for (int i = 0; i < 400 && rx_q.size() < base_rx + 6; i++) @(negedge clk);
        n_cmp++;
        if (rx_q.size() != base_rx + 6) begin n_fail++; $display("FAIL burst_rx_count: got %0d required 6", rx_q.size() - base_rx); end
        else begin
            for (int k = 0; k < 6; k++) begin
                n_cmp++; if (rx_q[base_rx+k] !== exp_rx[k]) begin n_fail++; $display("FAIL burst_rx%0d: got %h required %h", k, rx_q[base_rx+k], exp_rx[k]); end
                n_cmp++; if (mosi_q[base_mo+k] !== exp_mo[k]) begin n_fail++; $display("FAIL burst_mosi%0d: got %h required %h", k, mosi_q[base_mo+k], exp_mo[k]); end
            end
        end
    endtask

    task automatic test_rx_backpressure();
        bit ok;
        int base_rx;
        int base_st;
        base_rx = rx_q.size(); base_st = start_cnt;
        rx_ready = 1'b0;
        push_byte(8'h11, ok);
        push_byte(8'h22, ok);
        for (int i = 0; i < 100 && rx_valid !== 1'b1; i++) @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'h88) begin n_fail++; $display("FAIL bp_hold c%0d: got v=%b d=%h required v=1 d=88", i, rx_valid, rx_data); end
            n_cmp++; if (spi_start !== 1'b0) begin n_fail++; $display("FAIL bp_no_start c%0d: got %b required 0", i, spi_start); end
            @(negedge clk);
        end
        n_cmp++; if (start_cnt - base_st !== 1) begin n_fail++; $display("FAIL bp_one_xfer: got %0d required 1", start_cnt - base_st); end
        n_cmp++; if (tx_level !== 3'd1) begin n_fail++; $display("FAIL bp_level: got %0d required 1", tx_level); end
        rx_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b required 0", rx_valid); end
        n_cmp++; if (spi_start !== 1'b0) begin n_fail++; $display("FAIL bp_same_cycle_launch: got %b required 0", spi_start); end
        @(negedge clk);
        n_cmp++; if (spi_start !== 1'b1) begin n_fail++; $display("FAIL bp_launch2: got %b required 1", spi_start); end
        n_cmp++; if (spi_data_in !== 8'h22) begin n_fail++; $display("FAIL bp_mosi2: got %h required 22", spi_data_in); end
        for (int i = 0; i < 200 && rx_q.size() < base_rx + 2; i++) @(negedge clk);
        n_cmp++;
        if (rx_q.size() != base_rx + 2) begin n_fail++; $display("FAIL bp_rx_count: got %0d required 2", rx_q.size() - base_rx); end
        else begin
            n_cmp++; if (rx_q[base_rx] !== 8'h88) begin n_fail++; $display("FAIL bp_rx0: got %h required 88", rx_q[base_rx]); end
            n_cmp++; if (rx_q[base_rx+1] !== 8'hBB) begin n_fail++; $display("FAIL bp_rx1: got %h required bb", rx_q[base_rx+1]); end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int base_rx;
        base_rx = rx_q.size();
        slave_en = 1'b0;
        push_byte(8'h5A, ok);
        push_byte(8'h6B, ok);
        n_cmp++; if (spi_start !== 1'b1 || spi_data_in !== 8'h5A) begin n_fail++; $display("FAIL to_launch: got start=%b mosi=%h required 1/5a", spi_start, spi_data_in); end
        repeat (16) @(negedge clk);
        n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b required 0", timeout_err); end
        err_clr = 1'b1;
        @(negedge clk);
        n_cmp++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_set_wins: got %b required 1", timeout_err); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL to_no_rx: got %b required 0", rx_valid); end
        err_clr = 1'b0;
        slave_en = 1'b1;
        @(negedge clk);
        n_cmp++; if (spi_start !== 1'b1) begin n_fail++; $display("FAIL to_next_launch: got %b required 1", spi_start); end
        n_cmp++; if (spi_data_in !== 8'h6B) begin n_fail++; $display("FAIL to_next_mosi: got %h required 6b", spi_data_in); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b required 1", timeout_err); end
        for (int i = 0; i < 200 && rx_q.size() < base_rx + 1; i++) @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (rx_q.size() != base_rx + 1) begin n_fail++; $display("FAIL to_rx_count: got %0d required 1", rx_q.size() - base_rx); end
        else begin
            n_cmp++; if (rx_q[base_rx] !== 8'hF2) begin n_fail++; $display("FAIL to_rx: got %h required f2", rx_q[base_rx]); end
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b required 0", timeout_err); end
    endtask

    task automatic test_reset_mid_transfer();
        bit ok;
        int base_rx;
        int base_st;
        base_rx = rx_q.size();
        push_byte(8'hC1, ok);
        push_byte(8'hC2, ok);
        push_byte(8'hC3, ok);
        push_byte(8'hC4, ok);
        n_cmp++; if (tx_level !== 3'd3) begin n_fail++; $display("FAIL rm_level_pre: got %0d required 3", tx_level); end
        chk_hold = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (tx_level !== 3'd0) begin n_fail++; $display("FAIL rm_level: got %0d required 0", tx_level); end
        n_cmp++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL rm_ready: got %b required 0", tx_ready); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rm_rx_valid: got %b required 0", rx_valid); end
        n_cmp++; if (spi_start !== 1'b0) begin n_fail++; $display("FAIL rm_start: got %b required 0", spi_start); end
        n_cmp++; if (spi_data_in !== 8'h00) begin n_fail++; $display("FAIL rm_mosi: got %h required 00", spi_data_in); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rm_err: got %b required 0", timeout_err); end
        rst_n = 1'b1;
        base_st = start_cnt;
        repeat (30) @(negedge clk);
        n_cmp++; if (rx_q.size() != base_rx) begin n_fail++; $display("FAIL rm_no_rx: got %0d required 0", rx_q.size() - base_rx); end
        n_cmp++; if (start_cnt != base_st) begin n_fail++; $display("FAIL rm_no_start: got %0d required 0", start_cnt - base_st); end
        n_cmp++; if (tx_level !== 3'd0) begin n_fail++; $display("FAIL rm_level_post: got %0d required 0", tx_level); end
        chk_hold = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_push_pop_same_cycle();
        test_burst_full();
        test_rx_backpressure();
        test_timeout();
        test_reset_mid_transfer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
